// File: rtl/stepper_pulse_gen_if.sv
// Control/status bundle between the register bank and the STEP/DIR pulse generator.
// The register bank drives the requests as master; the generator is the slave.
interface stepper_pulse_gen_if #(
    parameter int unsigned CNT_W = 32
);

    // Requests from the register bank
    logic             enable_in;
    logic             start;
    logic             abort;
    logic             dir_in;
    logic [CNT_W-1:0] step_count;
    logic [CNT_W-1:0] step_period;

    // Driver pins and status back to the register bank
    logic             step_out;
    logic             dir_out;
    logic             en_n_out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] steps_done;

    modport master (
        output enable_in,
        output start,
        output abort,
        output dir_in,
        output step_count,
        output step_period,
        input  step_out,
        input  dir_out,
        input  en_n_out,
        input  busy,
        input  done,
        input  aborted,
        input  steps_done
    );

    modport slave (
        input  enable_in,
        input  start,
        input  abort,
        input  dir_in,
        input  step_count,
        input  step_period,
        output step_out,
        output dir_out,
        output en_n_out,
        output busy,
        output done,
        output aborted,
        output steps_done
    );

endinterface

// File: rtl/stepper_pulse_gen.sv
// STEP/DIR pulse generator for a Pololu-style stepper driver.
// A move issues step_count STEP pulses, each STEP_HIGH_CYCLES high, with rising edges
// eff_period clocks apart, after a DIR setup delay. All pin and status outputs are flops.
// DIR_SETUP_CYCLES and STEP_HIGH_CYCLES must both be at least 1.
module stepper_pulse_gen #(
    parameter int unsigned CNT_W            = 32,
    parameter int unsigned STEP_HIGH_CYCLES = 100,
    parameter int unsigned DIR_SETUP_CYCLES = 20
) (
    input logic                s00_axi_aclk,
    input logic                s00_axi_aresetn,
    stepper_pulse_gen_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StFin
    } state_e;

    // Interval counter reload values are "length - 1": the counter runs down to zero.
    localparam logic [CNT_W-1:0] SetupLoad = CNT_W'(DIR_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HighLoad  = CNT_W'(STEP_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HighLen   = CNT_W'(STEP_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(2 * STEP_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] One       = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;         // clocks left in the current phase, minus one
    logic [CNT_W-1:0] count_q;       // latched step_count
    logic [CNT_W-1:0] period_q;      // latched eff_period
    logic [CNT_W-1:0] steps_done_q;
    logic             step_q;
    logic             dir_q;
    logic             en_n_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;
    logic             rdy_q;         // low for the first edge after reset release

    logic [CNT_W-1:0] eff_period;
    logic [CNT_W-1:0] low_load;
    logic             start_ok;
    logic             cancel;

    // Period clamp keeps the LOW phase at least as long as the HIGH phase.
    always_comb begin
        eff_period = (bus.step_period > MinPeriod) ? bus.step_period : MinPeriod;
        low_load   = period_q - HighLen - One;
        // Abort wins over a coincident start; a disabled driver cannot start.
        start_ok   = bus.start & bus.enable_in & ~bus.abort & rdy_q;
        // Losing the enable mid-move is handled exactly like an abort.
        cancel     = bus.abort | ~bus.enable_in;
    end

    // Move sequencer with registered pin and status outputs.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            count_q      <= '0;
            period_q     <= '0;
            steps_done_q <= '0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            en_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            en_n_q    <= ~bus.enable_in;
            rdy_q     <= 1'b1;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        count_q      <= bus.step_count;
                        period_q     <= eff_period;
                        dir_q        <= bus.dir_in;
                        steps_done_q <= '0;
                        busy_q       <= 1'b1;
                        if (bus.step_count == '0) begin
                            state_q <= StFin;
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= StSetup;
                            cnt_q   <= SetupLoad;
                        end
                    end
                end

                StSetup, StHigh, StLow: begin
                    if (cancel) begin
                        // A pulse cut short in HIGH is not counted.
                        state_q   <= StIdle;
                        step_q    <= 1'b0;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        cnt_q     <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - One;
                    end else if (state_q == StSetup) begin
                        state_q <= StHigh;
                        step_q  <= 1'b1;
                        cnt_q   <= HighLoad;
                    end else if (state_q == StHigh) begin
                        state_q      <= StLow;
                        step_q       <= 1'b0;
                        steps_done_q <= steps_done_q + One;
                        cnt_q        <= low_load;
                    end else if (steps_done_q < count_q) begin
                        // steps_done never exceeds count_q, so it cannot overflow.
                        state_q <= StHigh;
                        step_q  <= 1'b1;
                        cnt_q   <= HighLoad;
                    end else begin
                        state_q <= StFin;
                        done_q  <= 1'b1;
                    end
                end

                StFin: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    step_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.step_out   = step_q;
    assign bus.dir_out    = dir_q;
    assign bus.en_n_out   = en_n_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.steps_done = steps_done_q;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Directed bench for stepper_pulse_gen with STEP_HIGH_CYCLES=4, DIR_SETUP_CYCLES=2.
// Cycle 0 is the cycle in which start is driven; cycle c shows outputs after c edges.
module tb_stepper_pulse_gen;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    stepper_pulse_gen_if #(.CNT_W(32)) sif ();

    stepper_pulse_gen #(
        .CNT_W            (32),
        .STEP_HIGH_CYCLES (4),
        .DIR_SETUP_CYCLES (2)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .bus             (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        step_log [0:63];
    logic        done_log [0:63];
    logic        busy_log [0:63];
    logic        dir_log  [0:63];
    logic        abrt_log [0:63];
    logic [31:0] sd_log   [0:63];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected STEP level: high for 4 cycles from each listed rising cycle.
    function automatic logic in_pulse(input int c, input int r0, input int r1, input int r2);
        return (c >= r0 && c < r0 + 4) || (c >= r1 && c < r1 + 4) || (c >= r2 && c < r2 + 4);
    endfunction

    // Log n cycles; optionally pulse abort or a second (dir-toggled) start at a given cycle.
    task automatic run(input int n, input int abort_at, input int restart_at);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            step_log[c] = sif.step_out;
            done_log[c] = sif.done;
            busy_log[c] = sif.busy;
            dir_log[c]  = sif.dir_out;
            abrt_log[c] = sif.aborted;
            sd_log[c]   = sif.steps_done;
            sif.abort   = (c == abort_at);
            if (c == restart_at) begin
                sif.start  = 1'b1;
                sif.dir_in = ~sif.dir_in;
            end else begin
                sif.start = 1'b0;
            end
        end
        sif.abort = 1'b0;
        sif.start = 1'b0;
    endtask

    task automatic go(input logic [31:0] cnt, input logic [31:0] per, input logic dir);
        @(negedge clk);
        sif.step_count  = cnt;
        sif.step_period = per;
        sif.dir_in      = dir;
        sif.start       = 1'b1;
    endtask

    initial begin
        logic any_done;
        n_assert        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        sif.enable_in   = 1'b1;
        sif.start       = 1'b0;
        sif.abort       = 1'b0;
        sif.dir_in      = 1'b0;
        sif.step_count  = '0;
        sif.step_period = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst step_out", 32'(sif.step_out), 32'd0);
        chk("rst dir_out", 32'(sif.dir_out), 32'd0);
        chk("rst en_n_out", 32'(sif.en_n_out), 32'd1);
        chk("rst busy", 32'(sif.busy), 32'd0);
        chk("rst done", 32'(sif.done), 32'd0);
        chk("rst aborted", 32'(sif.aborted), 32'd0);
        chk("rst steps_done", sif.steps_done, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("en_n after release", 32'(sif.en_n_out), 32'd0);

        // Basic move: count=3, period=10, dir=1
        go(3, 10, 1'b1);
        run(36, 0, 0);
        chk("s1 dir c1", 32'(dir_log[1]), 32'd1);
        chk("s1 busy c1", 32'(busy_log[1]), 32'd1);
        for (int c = 1; c <= 36; c++) begin
            chk($sformatf("s1 step c%0d", c), 32'(step_log[c]), 32'(in_pulse(c, 3, 13, 23)));
            chk($sformatf("s1 done c%0d", c), 32'(done_log[c]), 32'(c == 33));
        end
        chk("s1 steps_done c7", sd_log[7], 32'd1);
        chk("s1 busy c34", 32'(busy_log[34]), 32'd0);
        chk("s1 steps_done end", sd_log[36], 32'd3);

        // Period clamp: count=2, period=5 -> 8 (4 high, 4 low)
        go(2, 5, 1'b0);
        run(22, 0, 0);
        chk("s2 dir c1", 32'(dir_log[1]), 32'd0);
        for (int c = 1; c <= 22; c++) begin
            chk($sformatf("s2 step c%0d", c), 32'(step_log[c]), 32'(in_pulse(c, 3, 11, -100)));
            chk($sformatf("s2 done c%0d", c), 32'(done_log[c]), 32'(c == 19));
        end
        chk("s2 steps_done end", sd_log[22], 32'd2);

        // Zero-length move
        go(0, 10, 1'b1);
        run(4, 0, 0);
        chk("s3 done c1", 32'(done_log[1]), 32'd1);
        chk("s3 busy c1", 32'(busy_log[1]), 32'd1);
        chk("s3 steps_done c1", sd_log[1], 32'd0);
        chk("s3 done c2", 32'(done_log[2]), 32'd0);
        chk("s3 busy c2", 32'(busy_log[2]), 32'd0);
        for (int c = 1; c <= 4; c++)
            chk($sformatf("s3 step c%0d", c), 32'(step_log[c]), 32'd0);

        // Abort two cycles into the third HIGH
        go(5, 10, 1'b0);
        run(40, 24, 0);
        any_done = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            chk($sformatf("s4 step c%0d", c), 32'(step_log[c]),
                32'(in_pulse(c, 3, 13, 23) && c <= 24));
            any_done = any_done | done_log[c];
        end
        chk("s4 aborted c25", 32'(abrt_log[25]), 32'd1);
        chk("s4 aborted c26", 32'(abrt_log[26]), 32'd0);
        chk("s4 busy c25", 32'(busy_log[25]), 32'd0);
        chk("s4 steps_done c25", sd_log[25], 32'd2);
        chk("s4 steps_done end", sd_log[40], 32'd2);
        chk("s4 no done", 32'(any_done), 32'd0);

        // Second start mid-move with dir toggled is ignored
        go(2, 10, 1'b1);
        run(26, 0, 5);
        for (int c = 1; c <= 26; c++) begin
            chk($sformatf("s5 dir c%0d", c), 32'(dir_log[c]), 32'd1);
            chk($sformatf("s5 step c%0d", c), 32'(step_log[c]), 32'(in_pulse(c, 3, 13, -100)));
        end
        chk("s5 done c23", 32'(done_log[23]), 32'd1);
        chk("s5 steps_done end", sd_log[26], 32'd2);

        // Start while disabled is ignored
        @(negedge clk);
        sif.enable_in  = 1'b0;
        sif.step_count = 1;
        sif.start      = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        chk("dis busy", 32'(sif.busy), 32'd0);
        chk("dis en_n_out", 32'(sif.en_n_out), 32'd1);
        sif.enable_in = 1'b1;
        @(negedge clk);
        chk("ena en_n_out", 32'(sif.en_n_out), 32'd0);

        // Abort and start together: abort wins
        sif.start = 1'b1;
        sif.abort = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        sif.abort = 1'b0;
        chk("start+abort busy", 32'(sif.busy), 32'd0);
        chk("start+abort aborted", 32'(sif.aborted), 32'd0);

        // Enable dropping in LOW acts as abort
        go(2, 10, 1'b1);
        run(8, 0, 0);
        chk("en drop step c8", 32'(step_log[8]), 32'd0);
        sif.enable_in = 1'b0;
        @(negedge clk);
        chk("en drop busy", 32'(sif.busy), 32'd0);
        chk("en drop aborted", 32'(sif.aborted), 32'd1);
        chk("en drop steps_done", sif.steps_done, 32'd1);
        sif.enable_in = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset during HIGH, then a fresh move
        go(3, 10, 1'b1);
        run(4, 0, 0);
        chk("s6 step c4", 32'(step_log[4]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6 async step_out", 32'(sif.step_out), 32'd0);
        chk("s6 async en_n_out", 32'(sif.en_n_out), 32'd1);
        chk("s6 async busy", 32'(sif.busy), 32'd0);
        chk("s6 async done", 32'(sif.done), 32'd0);
        chk("s6 async aborted", 32'(sif.aborted), 32'd0);
        repeat (2) @(negedge clk);
        rst_n           = 1'b1;
        sif.step_count  = 1;
        sif.step_period = 10;
        sif.start       = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        chk("s6 first-edge start ignored", 32'(sif.busy), 32'd0);
        go(1, 10, 1'b1);
        run(14, 0, 0);
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("s6 step c%0d", c), 32'(step_log[c]), 32'(in_pulse(c, 3, -100, -100)));
            chk($sformatf("s6 done c%0d", c), 32'(done_log[c]), 32'(c == 13));
        end
        chk("s6 steps_done end", sd_log[14], 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stepper_pulse_gen.md
STEPPER_PULSE_GEN -- requirements
Module: stepper_pulse_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, the width of the count, period and progress fields.
REQ-002 The block SHALL have parameter STEP_HIGH_CYCLES, default 100, the STEP high time in clocks (1 us at 100 MHz).
REQ-003 The block SHALL have parameter DIR_SETUP_CYCLES, default 20, the DIR-to-first-STEP setup time in clocks.
REQ-004 The block SHALL have port s00_axi_aclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port s00_axi_aresetn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port enable_in, input, 1 bit: driver enable from the register bank.
REQ-007 The block SHALL have port start, input, 1 bit: single-cycle move request.
REQ-008 The block SHALL have port abort, input, 1 bit: single-cycle move cancel.
REQ-009 The block SHALL have port dir_in, input, 1 bit: requested direction.
REQ-010 The block SHALL have port step_count, input, CNT_W bits: number of steps to issue.
REQ-011 The block SHALL have port step_period, input, CNT_W bits: clocks from one STEP rising edge to the next.
REQ-012 The block SHALL have port step_out, output, 1 bit: STEP pin to the Pololu driver.
REQ-013 The block SHALL have port dir_out, output, 1 bit: DIR pin.
REQ-014 The block SHALL have port en_n_out, output, 1 bit: active-low ENABLE pin, equal to ~enable_in registered.
REQ-015 The block SHALL have port busy, output, 1 bit: move in progress.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-017 The block SHALL have port aborted, output, 1 bit: one-cycle pulse on abort completion.
REQ-018 The block SHALL have port steps_done, output, CNT_W bits: steps issued in the current or last move.

Function
REQ-019 The FSM SHALL have states IDLE, SETUP, HIGH, LOW and FIN.
REQ-020 In IDLE, start=1 with enable_in=1 SHALL have the following effects at the next edge: latch step_count, latch dir_in into dir_out, latch eff_period, clear steps_done, set busy=1, and enter SETUP.
REQ-021 eff_period SHALL be max(step_period, 2*STEP_HIGH_CYCLES), compared unsigned.
REQ-022 start with enable_in=0, and start while busy=1, SHALL be ignored with no state change.
REQ-023 start with step_count=0 SHALL go directly from IDLE to FIN with no STEP pulse and steps_done=0.
REQ-024 SETUP SHALL last exactly DIR_SETUP_CYCLES clocks with step_out=0, then enter HIGH.
REQ-025 HIGH SHALL last exactly STEP_HIGH_CYCLES clocks with step_out=1, then enter LOW.
REQ-026 On the HIGH-to-LOW transition, steps_done SHALL increment by 1.
REQ-027 LOW SHALL last eff_period-STEP_HIGH_CYCLES clocks with step_out=0.
REQ-028 At the end of LOW, the FSM SHALL enter HIGH if steps_done < latched count, otherwise FIN.
REQ-029 FIN SHALL last 1 clock with done=1; the next state is IDLE with busy=0.
REQ-030 dir_out SHALL change only on an accepted start and be held stable for the whole move.
REQ-031 step_out SHALL be driven directly from a flop, with no combinational path.
REQ-032 abort=1 in SETUP, HIGH or LOW SHALL, at the next edge, force step_out=0, assert aborted for 1 cycle, set busy=0, and return to IDLE.
REQ-033 On abort, steps_done SHALL hold its value; a STEP pulse cut short in HIGH is not counted.
REQ-034 abort in IDLE or FIN SHALL be ignored.
REQ-035 abort and start asserted in the same cycle SHALL give abort priority; start is dropped.
REQ-036 enable_in falling mid-move SHALL act as abort.
REQ-037 The interval counter SHALL be CNT_W bits wide and never wrap: loads are bounded by eff_period, which is at most 2^CNT_W-1.
REQ-038 step_count = 2^CNT_W-1 SHALL be supported without steps_done overflow.

Reset
REQ-039 While s00_axi_aresetn=0, the block SHALL hold state=IDLE, step_out=0, dir_out=0, en_n_out=1, busy=0, done=0, aborted=0, steps_done=0, and all counters at 0.
REQ-040 Reset asserted mid-move SHALL drop step_out to 0 immediately, asynchronously, without pulsing done or aborted.
REQ-041 After release, the block SHALL accept start no earlier than the second rising edge.

Verification (bench parameters: STEP_HIGH_CYCLES=4, DIR_SETUP_CYCLES=2)
REQ-042 The bench SHALL cover: start, count=3, period=10, dir=1 -> dir_out=1 at cycle 1; STEP rises at cycles 3, 13, 23, each high 4 clocks; done at cycle 33; steps_done=3.
REQ-043 The bench SHALL cover: start, count=2, period=5 -> clamped to 8; rising edges 8 clocks apart; 4-high/4-low pattern.
REQ-044 The bench SHALL cover: start, count=0 -> done one cycle after start; step_out never 1; busy high for 1 cycle.
REQ-045 The bench SHALL cover: count=5, period=10, abort 2 cycles into the third HIGH -> step_out=0 next edge; aborted pulse; steps_done=2; done never asserted.
REQ-046 The bench SHALL cover: second start mid-move with dir_in toggled -> ignored; dir_out unchanged; original count completes.
REQ-047 The bench SHALL cover: reset asserted during HIGH -> step_out=0 and en_n_out=1 without waiting for a clock edge; after release, a new move of count=1 completes normally.
